// File: rtl/st_reg_ram_fwd.sv
// ---------------------------------------------------------------------------
// st_reg_ram_fwd
//   Voice x envelope state-register RAM for the envelope generators. Holds one
//   D_WIDTH state word per slot (DEPTH = VOICES*V_ENVS). The block runs on one
//   clock and has same-edge write-to-read forwarding. A clear sequencer zeroes
//   every slot after reset and whenever clr_req is pulsed.
//
// Ports
//   sCLK_XVXENVS  : sole clock, rising edge
//   reset_reg_N   : async reset, active low (RAM contents are not reset)
//   write_address : write slot, presented one cycle ahead of d/we
//   d, we         : write data / write enable
//   read_address  : read slot; q is valid two edges later
//   clr_req       : single-cycle request to zero all slots (ignored while busy)
//   q             : registered read data
//   busy          : clear sweep in progress
// ---------------------------------------------------------------------------
module st_reg_ram_fwd #(
    parameter  int VOICES  = 8,
    parameter  int V_ENVS  = 8,
    parameter  int V_WIDTH = 3,
    parameter  int E_WIDTH = 3,
    parameter  int D_WIDTH = 117,
    localparam int AW      = V_WIDTH + E_WIDTH,
    localparam int DEPTH   = VOICES * V_ENVS
) (
    input  logic               sCLK_XVXENVS,
    input  logic               reset_reg_N,
    input  logic [AW-1:0]      write_address,
    input  logic [D_WIDTH-1:0] d,
    input  logic               we,
    input  logic [AW-1:0]      read_address,
    input  logic               clr_req,
    output logic [D_WIDTH-1:0] q,
    output logic               busy
);

    // One extra bit so DEPTH == 2^AW still compares correctly.
    localparam logic [AW:0]   DEPTH_C = (AW+1)'(DEPTH);
    localparam logic [AW-1:0] LAST    = AW'(DEPTH - 1);

    typedef enum logic {CLEAR, IDLE} state_e;

    state_e             state_q;
    logic [AW-1:0]      cnt_q;
    logic [AW-1:0]      wa_q;
    logic [AW-1:0]      ra_q;
    logic [D_WIDTH-1:0] q_q;
    logic               busy_q;

    logic [D_WIDTH-1:0] mem [DEPTH];

    logic               wa_ok, ra_ok, wr_commit;
    logic               mem_we_d;
    logic [AW-1:0]      mem_wa_d;
    logic [D_WIDTH-1:0] mem_wd_d;
    logic [D_WIDTH-1:0] rd_data_d;

    always_comb begin
        wa_ok     = {1'b0, wa_q} < DEPTH_C;
        ra_ok     = {1'b0, ra_q} < DEPTH_C;
        // clr_req takes priority over a write sampled in the same cycle.
        wr_commit = (state_q == IDLE) && we && !clr_req && wa_ok;

        mem_we_d  = (state_q == CLEAR) || wr_commit;
        mem_wa_d  = (state_q == CLEAR) ? cnt_q : wa_q;
        mem_wd_d  = (state_q == CLEAR) ? '0    : d;

        // Forward the word being written this edge so a read never sees
        // stale data for the slot being updated.
        rd_data_d = '0;
        if (ra_ok) begin
            if (wr_commit && (wa_q == ra_q))
                rd_data_d = d;
            else
                rd_data_d = mem[ra_q];
        end
    end

    // Storage array: no reset, the clear sweep initialises it.
    always_ff @(posedge sCLK_XVXENVS) begin
        if (mem_we_d)
            mem[mem_wa_d] <= mem_wd_d;
    end

    always_ff @(posedge sCLK_XVXENVS or negedge reset_reg_N) begin
        if (!reset_reg_N) begin
            state_q <= CLEAR;
            cnt_q   <= '0;
            wa_q    <= '0;
            ra_q    <= '0;
            q_q     <= '0;
            busy_q  <= 1'b1;
        end else begin
            // Address registers track their inputs every edge. During CLEAR
            // they have no effect, because writes and reads are suppressed.
            wa_q <= write_address;
            ra_q <= read_address;
            case (state_q)
                CLEAR: begin
                    q_q <= '0;
                    if (cnt_q == LAST) begin
                        state_q <= IDLE;
                        cnt_q   <= '0;
                        busy_q  <= 1'b0;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                IDLE: begin
                    q_q <= rd_data_d;
                    if (clr_req) begin
                        state_q <= CLEAR;
                        cnt_q   <= '0;
                        busy_q  <= 1'b1;
                    end
                end
                default: begin
                    state_q <= CLEAR;
                    cnt_q   <= '0;
                    busy_q  <= 1'b1;
                end
            endcase
        end
    end

    assign q    = q_q;
    assign busy = busy_q;

endmodule

// File: tb/tb_st_reg_ram_fwd.sv
module tb_st_reg_ram_fwd;

    logic         clk   = 1'b0;
    logic         rst_n = 1'b0;

    logic [5:0]   wa0 = '0, ra0 = '0, wa1 = '0, ra1 = '0;
    logic [116:0] d0 = '0, d1 = '0, q0, q1;
    logic         we0 = 1'b0, we1 = 1'b0, clr0 = 1'b0, clr1 = 1'b0;
    logic         busy0, busy1;

    int n_chk  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    st_reg_ram_fwd dut0 (
        .sCLK_XVXENVS (clk),
        .reset_reg_N  (rst_n),
        .write_address(wa0),
        .d            (d0),
        .we           (we0),
        .read_address (ra0),
        .clr_req      (clr0),
        .q            (q0),
        .busy         (busy0)
    );

    // DEPTH 48 instance for the out-of-range cases.
    st_reg_ram_fwd #(.VOICES(6), .V_ENVS(8)) dut1 (
        .sCLK_XVXENVS (clk),
        .reset_reg_N  (rst_n),
        .write_address(wa1),
        .d            (d1),
        .we           (we1),
        .read_address (ra1),
        .clr_req      (clr1),
        .q            (q1),
        .busy         (busy1)
    );

    task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input bit sel, input logic [5:0] a, input logic [116:0] v);
        if (sel) wa1 = a; else wa0 = a;
        tick();
        if (sel) begin d1 = v; we1 = 1'b1; end
        else     begin d0 = v; we0 = 1'b1; end
        tick();
        we0 = 1'b0;
        we1 = 1'b0;
    endtask

    task automatic rd(input bit sel, input logic [5:0] a, input logic [116:0] exp, input string tag);
        if (sel) ra1 = a; else ra0 = a;
        tick();
        tick();
        chk(tag, sel ? q1 : q0, exp);
    endtask

    task automatic busy_len(output int n);
        n = 0;
        while (busy0 && n < 200) begin
            tick();
            n++;
        end
    endtask

    initial begin
        int n, n1;

        // Reset state
        tick(); tick();
        chk("rst_busy", busy0, 1);
        chk("rst_q", q0, 0);
        chk("rst_busy1", busy1, 1);

        // Sweep after release: 64 cycles for the default, 48 for DEPTH 48
        rst_n = 1'b1;
        n = 0; n1 = 0;
        while ((busy0 || busy1) && n < 200) begin
            tick();
            n++;
            if (!busy1 && n1 == 0) n1 = n;
        end
        chk("rst_sweep_len", n, 64);
        chk("rst_sweep_len1", n1, 48);
        rd(0, 0,  0, "init_rd0");
        rd(0, 37, 0, "init_rd37");
        rd(0, 63, 0, "init_rd63");

        // Basic write/read
        wr(0, 10, 117'h1ABC);
        rd(0, 10, 117'h1ABC, "rd10");
        rd(0, 11, 0, "rd11");

        // Same-edge forwarding: commit edge equals the q-load edge
        wr(0, 5, 117'd7);
        rd(0, 5, 117'd7, "rd5_old");
        wa0 = 5; ra0 = 5;
        tick();
        d0 = 117'd9; we0 = 1'b1;
        tick();
        we0 = 1'b0;
        chk("fwd5", q0, 117'd9);
        rd(0, 5, 117'd9, "rd5_new");

        // Out of range on DEPTH 48
        wr(1, 50, 117'h55);
        rd(1, 50, 0, "oor_rd50");
        rd(1, 2,  0, "oor_rd2");
        wr(1, 47, 117'h33);
        rd(1, 47, 117'h33, "rd47_top");

        // Clear request; a we in the clr cycle is dropped (no forward to q)
        wr(0, 1, 117'd11);
        wr(0, 2, 117'd22);
        wr(0, 3, 117'd33);
        rd(0, 2, 117'd22, "pre_clr_rd2");
        wa0 = 4; ra0 = 4;
        tick();
        d0 = 117'hAA; we0 = 1'b1; clr0 = 1'b1;
        tick();
        we0 = 1'b0; clr0 = 1'b0;
        chk("clr_busy", busy0, 1);
        chk("clr_we_drop", q0, 0);
        n = 0;
        while (busy0 && n < 200) begin
            clr0 = (n == 10);   // second request mid-sweep must be ignored
            tick();
            n++;
            if (n == 5) chk("clr_q_zero", q0, 0);
        end
        clr0 = 1'b0;
        chk("clr_sweep_len", n, 64);
        rd(0, 1, 0, "clr_rd1");
        rd(0, 2, 0, "clr_rd2");
        rd(0, 3, 0, "clr_rd3");
        rd(0, 4, 0, "clr_rd4");
        rd(0, 10, 0, "clr_rd10");

        // Reset at sweep count 20 restarts the sweep
        wr(0, 60, 117'h77);
        rd(0, 60, 117'h77, "pre_rst_rd60");
        clr0 = 1'b1;
        tick();
        clr0 = 1'b0;
        repeat (20) tick();
        rst_n = 1'b0;
        #1;
        chk("midrst_busy", busy0, 1);
        chk("midrst_q", q0, 0);
        tick(); tick();
        chk("midrst_busy_hold", busy0, 1);
        rst_n = 1'b1;
        busy_len(n);
        chk("midrst_sweep_len", n, 64);
        rd(0, 60, 0, "midrst_rd60");
        rd(0, 0,  0, "midrst_rd0");
        rd(0, 20, 0, "midrst_rd20");

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

endmodule
